ex_stage_pipe: RTL and testbench

//  Registered, parametrised execute stage for the MUSA core, sitting between ID and MEM.
//  - Performs single-cycle ALU ops, iterative multi-cycle MUL/DIV/REM, and next-address/redirect calculation.
//  - Moves results to MEM through a valid/ready output register so MEM can stall EX.

---
 rtl/ex_pkg.sv | 36 +++
 rtl/ex_stage_pipe_if.sv | 38 +++
 rtl/ex_stage_pipe_muldiv_iter.sv | 150 +++++++++++++++
 rtl/ex_stage_pipe.sv | 190 +++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared types for the MUSA execute stage: op codes, FSM states, flag bit positions.
package ex_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_MUL  = 5'd11,
    ALU_DIV  = 5'd12,
    ALU_DIVU = 5'd13,
    ALU_REM  = 5'd14
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_t;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  function automatic logic is_muldiv(input alu_op_t op);
    return op inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM};
  endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// ID->EX operation bus and EX->MEM result bus, each with its own valid/ready pair.
interface ex_stage_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int JUMP_WIDTH = 26
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [4:0]            alu_control;
  logic [ADDR_WIDTH-1:0] pc_in;
  logic [JUMP_WIDTH-1:0] jump_address;
  logic                  branch;
  logic                  jump;
  logic                  jump_sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [2:0]            flag;
  logic [DATA_WIDTH-1:0] out_data_b;
  logic [ADDR_WIDTH-1:0] next_address;
  logic                  redirect;

  // Producer/consumer side (ID feeding ops, MEM taking results)
  modport master (
    output in_valid, data_a, data_b, alu_control, pc_in, jump_address,
           branch, jump, jump_sel, out_ready,
    input  in_ready, out_valid, result, flag, out_data_b, next_address, redirect
  );

  // Execute stage side
  modport slave (
    input  in_valid, data_a, data_b, alu_control, pc_in, jump_address,
           branch, jump, jump_sel, out_ready,
    output in_ready, out_valid, result, flag, out_data_b, next_address, redirect
  );
endinterface

// File: rtl/ex_stage_pipe_muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider, one bit per cycle for W cycles.
// Works on operand magnitudes and fixes signs once the iteration finishes.
module muldiv_iter
  import ex_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_i,
  input  alu_op_t      op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] res_o,
  output logic         ovf_o
);
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  alu_op_t       op_q, op_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // hi: running product high half / partial remainder; lo: multiplier / quotient
  logic [W:0]    hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  a_q, a_d;
  logic          neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d, dovf_q, dovf_d;

  logic          sgn, sa, sb;
  logic [W-1:0]  ma, mb;
  logic [W:0]    msum, rs;
  logic [W+1:0]  diff;

  // Operand magnitudes and one iteration step of each algorithm
  always_comb begin
    sgn  = (op_i != ALU_DIVU);
    sa   = sgn & a_i[W-1];
    sb   = sgn & b_i[W-1];
    ma   = sa ? -a_i : a_i;
    mb   = sb ? -b_i : b_i;
    msum = hi_q + (lo_q[0] ? {1'b0, dvs_q} : '0);
    rs   = {hi_q[W-1:0], lo_q[W-1]};
    diff = {1'b0, rs} - {2'b00, dvs_q};
  end

  // Next-state: load on start, otherwise iterate while busy
  always_comb begin
    op_d   = op_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dvs_d  = dvs_q;
    a_d    = a_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    div0_d = div0_q;
    dovf_d = dovf_q;
    if (start_i) begin
      op_d   = op_i;
      busy_d = 1'b1;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = ma;
      dvs_d  = mb;
      a_d    = a_i;
      neg_d  = sa ^ sb;
      rneg_d = sa;
      div0_d = (b_i == '0);
      dovf_d = (op_i == ALU_DIV) && (a_i == MIN_NEG) && (b_i == '1);
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W-1)) busy_d = 1'b0;
      if (op_q == ALU_MUL) begin
        hi_d = {1'b0, msum[W:1]};
        lo_d = {msum[0], lo_q[W-1:1]};
      end else if (!diff[W+1]) begin
        hi_d = diff[W:0];
        lo_d = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_d = rs;
        lo_d = {lo_q[W-2:0], 1'b0};
      end
    end
  end

  // Iteration registers
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q   <= ALU_ADD;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dvs_q  <= '0;
      a_q    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      div0_q <= 1'b0;
      dovf_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dvs_q  <= dvs_d;
      a_q    <= a_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      div0_q <= div0_d;
      dovf_q <= dovf_d;
    end
  end

  logic [2*W-1:0] prod, sprod;
  logic [W-1:0]   quo, rem;

  // Sign fix-up and the divide-by-zero / overflow special cases
  always_comb begin
    prod  = {hi_q[W-1:0], lo_q};
    sprod = neg_q ? -prod : prod;
    quo   = neg_q ? -lo_q : lo_q;
    rem   = rneg_q ? -hi_q[W-1:0] : hi_q[W-1:0];
    res_o = quo;
    ovf_o = dovf_q;
    case (op_q)
      ALU_MUL: begin
        res_o = sprod[W-1:0];
        ovf_o = (sprod[2*W-1:W] != {W{sprod[W-1]}});
      end
      ALU_REM: begin
        res_o = div0_q ? a_q : rem;
        ovf_o = div0_q;
      end
      default: begin
        res_o = div0_q ? '1 : quo;
        ovf_o = div0_q | dovf_q;
      end
    endcase
  end

  assign busy_o = busy_q;
  // High during the last iteration cycle; result is stable from the following cycle
  assign done_o = busy_q && (cnt_q == CW'(W-1));

endmodule

// File: rtl/ex_stage_pipe.sv
// MUSA execute stage: single-cycle ALU, iterative MUL/DIV/REM, branch/jump target,
// all results registered behind a valid/ready output stage towards MEM.
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int JUMP_WIDTH = 26,
  parameter int MULDIV_EN  = 1
) (
  input logic            clock,
  input logic            reset,
  ex_stage_pipe_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int SH = $clog2(W);

  typedef struct packed {
    logic [W-1:0]  result;
    logic [2:0]    flag;
    logic [W-1:0]  data_b;
    logic [AW-1:0] next_address;
    logic          redirect;
  } out_t;

  // Side information of a multi-cycle op, held until its result is loaded
  typedef struct packed {
    logic [W-1:0]  data_b;
    logic [AW-1:0] next_address;
    logic          redirect;
  } pend_t;

  ex_state_t state_q, state_d;
  out_t      out_q, out_d;
  logic      out_valid_q, out_valid_d;
  pend_t     pend_q, pend_d;

  alu_op_t       op;
  logic          md_op;
  logic [W-1:0]  a, b, sum, dif, alu_res;
  logic [SH-1:0] sh;
  logic          alu_ovf;

  assign op    = alu_op_t'(bus.alu_control);
  assign md_op = (MULDIV_EN != 0) && is_muldiv(op);
  assign a     = bus.data_a;
  assign b     = bus.data_b;
  assign sh    = b[SH-1:0];
  assign sum   = a + b;
  assign dif   = a - b;

  // Single-cycle ALU; MUL/DIV/REM fall back to ADD when no iterative unit exists
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      ALU_ADD, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM: begin
        alu_res = sum;
        alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        alu_res = dif;
        alu_ovf = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
      end
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res = {{(W-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_res = a << sh;
      ALU_SRL:  alu_res = a >> sh;
      ALU_SRA:  alu_res = $signed(a) >>> sh;
      default:  ;
    endcase
  end

  logic [AW-1:0]      na;
  logic               redir;
  logic signed [15:0] boff;

  assign boff = bus.jump_address[15:0];

  // Redirect target; the branch condition is the SUB-zero test, independent of op
  always_comb begin
    na    = bus.pc_in;
    redir = 1'b0;
    if (bus.jump) begin
      redir = 1'b1;
      na    = bus.jump_sel ? AW'(bus.data_a)
                           : {bus.pc_in[AW-1:JUMP_WIDTH+2], bus.jump_address, 2'b00};
    end else if (bus.branch && (bus.data_a == bus.data_b)) begin
      redir = 1'b1;
      na    = bus.pc_in + (AW'(boff) << 2);
    end
  end

  logic         can_load, accept, md_start, md_busy, md_done, md_ovf;
  logic [W-1:0] md_res;

  assign can_load     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !reset && (state_q == ST_IDLE) && can_load;
  assign accept       = bus.in_valid && bus.in_ready;

  generate
    if (MULDIV_EN != 0) begin : g_md
      muldiv_iter #(.W(W)) u_md (
        .clock  (clock),
        .reset  (reset),
        .start_i(md_start),
        .op_i   (op),
        .a_i    (a),
        .b_i    (b),
        .busy_o (md_busy),
        .done_o (md_done),
        .res_o  (md_res),
        .ovf_o  (md_ovf)
      );
    end else begin : g_no_md
      assign md_busy = 1'b0;
      assign md_done = 1'b0;
      assign md_res  = '0;
      assign md_ovf  = 1'b0;
    end
  endgenerate

  // FSM next-state and output-register loads
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    pend_d      = pend_q;
    md_start    = 1'b0;
    out_valid_d = out_valid_q && !bus.out_ready;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (md_op) begin
            md_start = 1'b1;
            pend_d   = '{data_b: b, next_address: na, redirect: redir};
            state_d  = ST_BUSY;
          end else begin
            out_d = '{result: alu_res,
                      flag: {alu_ovf, alu_res[W-1], alu_res == '0},
                      data_b: b, next_address: na, redirect: redir};
            out_valid_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (md_done)      state_d = ST_DONE;
        else if (!md_busy) state_d = ST_IDLE;  // unit lost its op: never wait forever
      end
      ST_DONE: begin
        if (can_load) begin
          out_d = '{result: md_res,
                    flag: {md_ovf, md_res[W-1], md_res == '0},
                    data_b: pend_q.data_b, next_address: pend_q.next_address,
                    redirect: pend_q.redirect};
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pending-op and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.result       = out_q.result;
  assign bus.flag         = out_q.flag;
  assign bus.out_data_b   = out_q.data_b;
  assign bus.next_address = out_q.next_address;
  assign bus.redirect     = out_q.redirect;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed corner cases plus random ops against an
// arithmetic reference model.
module tb_ex_stage_pipe;
  import ex_pkg::*;

  localparam int W  = 32;
  localparam int AW = 32;
  localparam int JW = 26;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;

  ex_stage_pipe_if #(.DATA_WIDTH(W), .ADDR_WIDTH(AW), .JUMP_WIDTH(JW)) bus();

  ex_stage_pipe #(.DATA_WIDTH(W), .ADDR_WIDTH(AW), .JUMP_WIDTH(JW), .MULDIV_EN(1)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference result/flags from plain 64-bit integer arithmetic
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [2:0] f);
    longint sa, sb, ua, ub, t, lim;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    lim = 64'sd2147483648;
    ovf = 1'b0;
    r   = '0;
    t   = 0;
    case (op)
      0:  begin t = sa + sb; r = t[31:0]; ovf = (t >= lim) || (t < -lim); end
      1:  begin t = sa - sb; r = t[31:0]; ovf = (t >= lim) || (t < -lim); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a | b);
      6:  r = (sa < sb) ? 32'd1 : 32'd0;
      7:  r = (ua < ub) ? 32'd1 : 32'd0;
      8:  r = a << b[4:0];
      9:  r = a >> b[4:0];
      10: begin t = sa >>> b[4:0]; r = t[31:0]; end
      11: begin t = sa * sb; r = t[31:0]; ovf = (t >= lim) || (t < -lim); end
      12: if (b == 0) begin r = '1; ovf = 1'b1; end
          else begin t = sa / sb; r = t[31:0]; ovf = (t >= lim); end
      13: if (b == 0) begin r = '1; ovf = 1'b1; end
          else begin t = ua / ub; r = t[31:0]; end
      14: if (b == 0) begin r = a; ovf = 1'b1; end
          else begin t = sa % sb; r = t[31:0]; end
      default: r = '0;
    endcase
    f = {ovf, r[31], r == 0};
  endfunction

  function automatic logic [31:0] model_na(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] pc, input logic [25:0] ja,
                                           input logic br, input logic jp, input logic js,
                                           output logic redir);
    int off;
    off   = int'($signed(ja[15:0]));
    redir = 1'b1;
    if (jp && js)          return a;
    if (jp)                return (pc & 32'hF000_0000) | (32'(ja) * 4);
    if (br && (a == b))    return pc + 32'(off * 4);
    redir = 1'b0;
    return pc;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic drive(input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [25:0] ja,
                       input logic br, input logic jp, input logic js);
    bus.alu_control  = 5'(op);
    bus.data_a       = a;
    bus.data_b       = b;
    bus.pc_in        = pc;
    bus.jump_address = ja;
    bus.branch       = br;
    bus.jump         = jp;
    bus.jump_sel     = js;
  endtask

  // Issue one op, wait for its result, check everything, optionally stall MEM
  task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [25:0] ja,
                        input logic br, input logic jp, input logic js, input int stall);
    logic [31:0] er, ena;
    logic [2:0]  ef;
    logic        erd;
    int          n, lat, nr;
    bit          md;
    model(op, a, b, er, ef);
    ena = model_na(a, b, pc, ja, br, jp, js, erd);
    md  = (op >= 11) && (op <= 14);
    drive(op, a, b, pc, ja, br, jp, js);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    chk({tag, ".accept_wait_ok"}, 64'(n < 100), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    nr  = 0;
    while (!bus.out_valid && lat < 200) begin
      if (!bus.in_ready) nr++;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), md ? 64'(W + 1) : 64'd0);
    if (md) chk({tag, ".in_ready_low_cycles"}, 64'(nr), 64'(W + 1));
    chk({tag, ".result"},       64'(bus.result),       64'(er));
    chk({tag, ".flag"},         64'(bus.flag),         64'(ef));
    chk({tag, ".out_data_b"},   64'(bus.out_data_b),   64'(b));
    chk({tag, ".redirect"},     64'(bus.redirect),     64'(erd));
    chk({tag, ".next_address"}, 64'(bus.next_address), 64'(ena));
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        tick();
        chk({tag, ".hold_result"},   64'(bus.result),    64'(er));
        chk({tag, ".hold_valid"},    64'(bus.out_valid), 64'd1);
        chk({tag, ".hold_in_ready"}, 64'(bus.in_ready),  64'd0);
      end
      bus.out_ready = 1'b1;
    end
  endtask

  initial begin
    int viol;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(0, 32'd1, 32'd1, 32'h0, 26'h0, 1'b0, 1'b0, 1'b0);

    // Reset, with an op presented throughout: reset must win
    tick();
    tick();
    chk("rst.in_ready_during", 64'(bus.in_ready), 64'd0);
    chk("rst.out_valid_during", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst.in_ready_after", 64'(bus.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.result", 64'(bus.result), 64'd0);
    chk("rst.flag", 64'(bus.flag), 64'd0);
    chk("rst.next_address", 64'(bus.next_address), 64'd0);
    chk("rst.redirect", 64'(bus.redirect), 64'd0);
    chk("rst.out_data_b", 64'(bus.out_data_b), 64'd0);

    // Directed corner cases
    run_op("add_ovf", 0, 32'h7FFF_FFFF, 32'd1, 32'h10, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("add_ovf.const_result", 64'(bus.result), 64'h8000_0000);
    chk("add_ovf.const_flag", 64'(bus.flag), 64'b110);
    run_op("div_neg", 12, -32'sd100, 32'd7, 32'h20, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("div_neg.const_result", 64'(bus.result), 64'hFFFF_FFF2);
    chk("div_neg.const_flag", 64'(bus.flag), 64'b010);
    run_op("rem_neg", 14, -32'sd100, 32'd7, 32'h24, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("rem_neg.const_result", 64'(bus.result), 64'hFFFF_FFFE);
    run_op("divu_zero", 13, 32'd5, 32'd0, 32'h28, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("divu_zero.const_result", 64'(bus.result), 64'hFFFF_FFFF);
    chk("divu_zero.const_ovf", 64'(bus.flag[2]), 64'd1);
    run_op("rem_zero", 14, 32'd5, 32'd0, 32'h2C, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("rem_zero.const_result", 64'(bus.result), 64'd5);
    run_op("div_minneg", 12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h30, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("div_minneg.const_result", 64'(bus.result), 64'h8000_0000);
    run_op("mul_ovf", 11, 32'h0001_0000, 32'h0001_0000, 32'h34, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("mul_neg", 11, -32'sd3, 32'd7, 32'h38, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("undef_op", 20, 32'd9, 32'd9, 32'h3C, 26'h0, 1'b0, 1'b0, 1'b0, 0);
    chk("undef_op.const_flag", 64'(bus.flag), 64'b001);
    run_op("branch", 1, 32'd5, 32'd5, 32'h100, 26'h0FFFF, 1'b1, 1'b0, 1'b0, 0);
    chk("branch.const_next_address", 64'(bus.next_address), 64'hFC);
    chk("branch.const_redirect", 64'(bus.redirect), 64'd1);
    run_op("jump_reg", 0, 32'h4000, 32'd0, 32'h100, 26'h0, 1'b0, 1'b1, 1'b1, 0);
    chk("jump_reg.const_next_address", 64'(bus.next_address), 64'h4000);
    run_op("jump_imm", 2, 32'h1, 32'h3, 32'hA000_0100, 26'h12_3456, 1'b1, 1'b1, 1'b0, 0);

    // MEM back-pressure: ADD 3+4 held for 4 cycles while the next op waits
    drive(0, 32'd3, 32'd4, 32'h40, 26'h0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive(0, 32'd10, 32'd20, 32'h44, 26'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall.first_result", 64'(bus.result), 64'd7);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall.hold_result", 64'(bus.result), 64'd7);
      chk("stall.hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall.hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall.release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("stall.next_result", 64'(bus.result), 64'd30);
    chk("stall.next_valid", 64'(bus.out_valid), 64'd1);
    tick();
    chk("stall.drained", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a divide: no result may ever appear
    drive(12, 32'd1000, 32'd3, 32'h50, 26'h0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_busy.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_busy.out_valid", 64'(bus.out_valid), 64'd0);
    viol = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid) viol++;
    end
    chk("rst_busy.no_output", 64'(viol), 64'd0);
    run_op("rst_busy.add", 0, 32'd11, 32'd22, 32'h60, 26'h0, 1'b0, 1'b0, 1'b0, 0);

    // Random ops with random redirect controls and occasional MEM stalls
    for (int k = 0; k < 60; k++) begin
      logic [31:0] ra, rb;
      ra = pick();
      rb = ($urandom_range(0, 3) == 0) ? ra : pick();
      run_op("rnd", int'($urandom_range(0, 17)), ra, rb, $urandom() & 32'hFFFF_FFFC,
             26'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
